run_sequencer: RTL and testbench

Synthesizable host-side controller that drives a CPU core's `start`/`halt` run interface and owns its data memory around each run. It sits beside the core and data memory, behind a 2:1 memory-port mux.
- Before a run: clears data memory, writes streamed preload bytes, then holds `start` high and releases the core.
- After `halt` (or a timeout): drains a window of result bytes out on a valid/ready stream.

---
 rtl/run_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_run_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/run_sequencer.sv
// run_sequencer: host-side controller for a CPU core's start/halt interface.
// Clears data memory, writes streamed preload bytes, launches the core, times the run,
// then drains a window of result bytes out on a valid/ready stream.
module run_sequencer #(
   parameter int MEM_DEPTH    = 256,
   parameter int START_CYCLES = 2,
   parameter int TIMEOUT      = 65535,
   parameter int RES_BASE     = 16,
   parameter int RES_COUNT    = 3
) (
   input  logic        CLK,
   input  logic        reset,
   input  logic        go,
   input  logic        ld_valid,
   output logic        ld_ready,
   input  logic [7:0]  ld_addr,
   input  logic [7:0]  ld_data,
   input  logic        ld_last,
   output logic        core_start,
   input  logic        core_halt,
   output logic        mem_sel,
   output logic        mem_we,
   output logic [7:0]  mem_addr,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [7:0]  res_data,
   output logic [7:0]  res_addr,
   output logic        res_last,
   output logic        busy,
   output logic        done,
   output logic        timeout,
   output logic [15:0] cycles
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_LOAD,
      S_LAUNCH,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   localparam logic [15:0] CLR_LAST    = 16'(MEM_DEPTH - 1);
   localparam logic [15:0] START_LAST  = 16'(START_CYCLES - 1);
   localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);
   localparam logic [15:0] BEAT_LAST   = 16'(RES_COUNT - 1);
   localparam logic [7:0]  BASE_ADDR   = 8'(RES_BASE);

   state_t      state_reg, state_next;
   // Shared phase counter: clear address in CLEAR, launch cycle in LAUNCH, beat index in DRAIN.
   logic [15:0] cnt_reg, cnt_next;
   logic [15:0] cycles_reg, cycles_next;
   logic [7:0]  ptr_reg, ptr_next;
   logic        timeout_reg, timeout_next;
   logic [15:0] run_inc;

   assign run_inc = cycles_reg + 16'd1;
   assign cycles  = cycles_reg;
   assign timeout = timeout_reg;

   // State and counter registers; reset returns to IDLE from anywhere.
   always_ff @(posedge CLK) begin
      if (reset) begin
         state_reg   <= S_IDLE;
         cnt_reg     <= '0;
         cycles_reg  <= '0;
         ptr_reg     <= '0;
         timeout_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         cycles_reg  <= cycles_next;
         ptr_reg     <= ptr_next;
         timeout_reg <= timeout_next;
      end
   end

   // Next-state logic and per-state drive of memory port, core control and streams.
   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      cycles_next  = cycles_reg;
      ptr_next     = ptr_reg;
      timeout_next = timeout_reg;
      ld_ready     = 1'b0;
      core_start   = 1'b1;
      mem_sel      = 1'b1;
      mem_we       = 1'b0;
      mem_addr     = 8'd0;
      mem_wdata    = 8'd0;
      res_valid    = 1'b0;
      res_data     = 8'd0;
      res_addr     = 8'd0;
      res_last     = 1'b0;
      busy         = 1'b0;
      done         = 1'b0;

      case (state_reg)
         S_IDLE, S_DONE: begin
            done = (state_reg == S_DONE);
            if (go) begin
               state_next   = S_CLEAR;
               cnt_next     = '0;
               cycles_next  = '0;
               timeout_next = 1'b0;
            end
         end
         S_CLEAR: begin
            busy     = 1'b1;
            mem_we   = 1'b1;
            mem_addr = cnt_reg[7:0];
            if (cnt_reg == CLR_LAST) begin
               state_next = S_LOAD;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + 16'd1;
            end
         end
         S_LOAD: begin
            busy     = 1'b1;
            ld_ready = 1'b1;
            if (ld_valid) begin
               mem_we    = 1'b1;
               mem_addr  = ld_addr;
               mem_wdata = ld_data;
               if (ld_last) begin
                  state_next = S_LAUNCH;
                  cnt_next   = '0;
               end
            end
         end
         S_LAUNCH: begin
            // Core is still held in reset here, so its halt flag means nothing yet.
            busy    = 1'b1;
            mem_sel = 1'b0;
            if (cnt_reg == START_LAST) begin
               state_next  = S_RUN;
               cnt_next    = '0;
               cycles_next = '0;
            end else begin
               cnt_next = cnt_reg + 16'd1;
            end
         end
         S_RUN: begin
            busy       = 1'b1;
            mem_sel    = 1'b0;
            core_start = 1'b0;
            if (core_halt) begin
               state_next = S_DRAIN;
               ptr_next   = BASE_ADDR;
               cnt_next   = '0;
            end else begin
               cycles_next = run_inc;
               if (run_inc == TIMEOUT_CNT) begin
                  timeout_next = 1'b1;
                  state_next   = S_DRAIN;
                  ptr_next     = BASE_ADDR;
                  cnt_next     = '0;
               end
            end
         end
         S_DRAIN: begin
            busy      = 1'b1;
            res_valid = 1'b1;
            mem_addr  = ptr_reg;
            res_addr  = ptr_reg;
            res_data  = mem_rdata;
            res_last  = (cnt_reg == BEAT_LAST);
            if (res_ready) begin
               // 8-bit pointer wraps 255 -> 0 naturally.
               ptr_next = ptr_reg + 8'd1;
               if (cnt_reg == BEAT_LAST) begin
                  state_next = S_DONE;
               end else begin
                  cnt_next = cnt_reg + 16'd1;
               end
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_run_sequencer.sv
// Bench for run_sequencer: two instances in lockstep (result base 16 and 254) with
// a behavioural data memory and core model each; scoreboard queues for writes and results.
module tb_run_sequencer;

   logic        CLK;
   logic        reset;
   logic        go;
   logic        ld_valid;
   logic [7:0]  ld_addr;
   logic [7:0]  ld_data;
   logic        ld_last;
   logic        res_ready;

   logic [1:0]  ld_ready, core_start, core_halt, mem_sel, mem_we;
   logic [1:0]  res_valid, res_last, busy, done, timeout;
   logic [7:0]  mem_addr [2];
   logic [7:0]  mem_wdata [2];
   logic [7:0]  mem_rdata [2];
   logic [7:0]  res_data [2];
   logic [7:0]  res_addr [2];
   logic [15:0] cycles [2];

   int          halt_after;
   logic        halt_force;

   int          tests;
   int          fails;

   logic [15:0] exp_wr [$];
   logic [16:0] exp_res0 [$];
   logic [16:0] exp_res1 [$];

   logic [7:0]  pl_addr [4];
   logic [7:0]  pl_data [4];

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      localparam int BASE = (gi == 0) ? 16 : 254;
      logic [7:0] mem [256];
      int         run_cnt;

      run_sequencer #(
         .MEM_DEPTH(256), .START_CYCLES(2), .TIMEOUT(100), .RES_BASE(BASE), .RES_COUNT(3)
      ) dut (
         .CLK(CLK), .reset(reset), .go(go),
         .ld_valid(ld_valid), .ld_ready(ld_ready[gi]), .ld_addr(ld_addr),
         .ld_data(ld_data), .ld_last(ld_last),
         .core_start(core_start[gi]), .core_halt(core_halt[gi]),
         .mem_sel(mem_sel[gi]), .mem_we(mem_we[gi]), .mem_addr(mem_addr[gi]),
         .mem_wdata(mem_wdata[gi]), .mem_rdata(mem_rdata[gi]),
         .res_valid(res_valid[gi]), .res_ready(res_ready), .res_data(res_data[gi]),
         .res_addr(res_addr[gi]), .res_last(res_last[gi]),
         .busy(busy[gi]), .done(done[gi]), .timeout(timeout[gi]), .cycles(cycles[gi])
      );

      assign mem_rdata[gi] = mem[mem_addr[gi]];

      // Memory with stale contents (0x5A) loaded during reset; core counts cycles out of reset.
      always @(posedge CLK) begin
         if (reset) begin
            for (int a = 0; a < 256; a++) mem[a] <= 8'h5A;
         end else if (mem_sel[gi] === 1'b1 && mem_we[gi] === 1'b1) begin
            mem[mem_addr[gi]] <= mem_wdata[gi];
         end
         if (core_start[gi] !== 1'b0) run_cnt <= 0;
         else run_cnt <= run_cnt + 1;
      end

      assign core_halt[gi] = halt_force |
                             ((halt_after >= 0) && (core_start[gi] == 1'b0) && (run_cnt >= halt_after));
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic step;
      @(posedge CLK);
      #1;
   endtask

   // Result scoreboard for one instance: every valid cycle must present the queue head.
   task automatic mon_res(input int i);
      logic [16:0] e;
      int          sz;
      sz = (i == 0) ? exp_res0.size() : exp_res1.size();
      if (res_valid[i] === 1'b1) begin
         if (sz == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL res_unexpected inst%0d: got addr %0d data %02h, required no beat",
                     i, res_addr[i], res_data[i]);
         end else begin
            e = (i == 0) ? exp_res0[0] : exp_res1[0];
            check($sformatf("res_beat_inst%0d", i),
                  32'({res_last[i], res_addr[i], res_data[i]}), 32'(e));
            if (res_ready === 1'b1) begin
               $display("[TB] inst%0d result addr %0d data %02h last %0d",
                        i, res_addr[i], res_data[i], res_last[i]);
               if (i == 0) void'(exp_res0.pop_front());
               else void'(exp_res1.pop_front());
            end
         end
      end
   endtask

   // Monitor: memory writes and result beats, sampled mid-cycle.
   always @(negedge CLK) begin
      if (mem_we[0] === 1'b1 || mem_we[1] === 1'b1) begin
         if (exp_wr.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL wr_unexpected: got addr %0d data %02h, required no write",
                     mem_addr[0], mem_wdata[0]);
         end else begin
            for (int i = 0; i < 2; i++)
               check($sformatf("mem_write_inst%0d", i),
                     32'({mem_sel[i], mem_we[i], mem_addr[i], mem_wdata[i]}),
                     32'({2'b11, exp_wr[0]}));
            void'(exp_wr.pop_front());
         end
      end
      for (int i = 0; i < 2; i++) mon_res(i);
   end

   task automatic check_idle_reset;
      for (int i = 0; i < 2; i++) begin
         check("rst_core_start", 32'(core_start[i]), 32'd1);
         check("rst_mem_sel", 32'(mem_sel[i]), 32'd1);
         check("rst_flags", 32'({busy[i], done[i], timeout[i], res_valid[i], ld_ready[i], mem_we[i]}), 32'd0);
         check("rst_cycles", 32'(cycles[i]), 32'd0);
      end
   endtask

   task automatic do_run(input int nb, input int halt_n, input bit go_in_load,
                         input bit halt_in_launch, input bit bp, input bit abort10,
                         input logic [15:0] exp_cycles, input logic exp_to);
      int n;
      halt_after = halt_n;
      for (int a = 0; a < 256; a++) exp_wr.push_back({8'(a), 8'h00});
      go = 1'b1;
      step;
      go = 1'b0;
      check("clear_entry_flags", 32'({busy[0], done[0], timeout[0]}), 32'b100);
      check("clear_entry_cycles", 32'(cycles[0]), 32'd0);
      n = 0;
      while (ld_ready[0] !== 1'b1 && n < 400) begin step; n++; end
      check("clear_len", 32'(n), 32'd256);
      for (int i = 0; i < nb; i++) begin
         exp_wr.push_back({pl_addr[i], pl_data[i]});
         ld_valid = 1'b1;
         ld_addr  = pl_addr[i];
         ld_data  = pl_data[i];
         ld_last  = (i == nb - 1);
         go       = go_in_load && (i == 0);
         step;
      end
      ld_valid = 1'b0;
      ld_last  = 1'b0;
      go       = 1'b0;
      n = 0;
      while (core_start[0] === 1'b1 && mem_sel[0] === 1'b0 && n < 20) begin
         halt_force = halt_in_launch && (n == 0);
         n++;
         step;
      end
      halt_force = 1'b0;
      check("launch_len", 32'(n), 32'd2);
      check("run_entry", 32'({core_start[0], mem_sel[0], busy[0]}), 32'b001);
      if (abort10) begin
         repeat (9) step;
         check("run_track_cycles", 32'(cycles[0]), 32'd9);
         reset = 1'b1;
         step;
         reset = 1'b0;
         check_idle_reset();
         repeat (3) step;
         check("abort_stays_idle", 32'({busy[0], res_valid[0]}), 32'd0);
         return;
      end
      res_ready = !bp;
      n = 0;
      while (res_valid[0] !== 1'b1 && n < 300) begin step; n++; end
      check("drain_reached", 32'(n < 300), 32'd1);
      for (int i = 0; i < 2; i++) begin
         check("drain_cycles", 32'(cycles[i]), 32'(exp_cycles));
         check("drain_timeout", 32'(timeout[i]), 32'(exp_to));
         check("drain_port", 32'({mem_sel[i], core_start[i], mem_we[i]}), 32'b110);
      end
      n = 0;
      while (done[0] !== 1'b1 && n < 60) begin
         if (bp) res_ready = (n >= 5) && (((n - 5) % 2) == 0);
         step;
         n++;
      end
      res_ready = 1'b0;
      check("drain_len", 32'(n), bp ? 32'd10 : 32'd3);
      repeat (3) step;
      for (int i = 0; i < 2; i++) begin
         check("done_flags", 32'({done[i], busy[i], res_valid[i]}), 32'b100);
         check("done_cycles_hold", 32'(cycles[i]), 32'(exp_cycles));
         check("done_timeout_hold", 32'(timeout[i]), 32'(exp_to));
      end
      check("res_queue0_empty", 32'(exp_res0.size()), 32'd0);
      check("res_queue1_empty", 32'(exp_res1.size()), 32'd0);
      check("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
      $display("[TB] run complete: cycles %0d timeout %0d", cycles[0], timeout[0]);
   endtask

   initial begin
      tests      = 0;
      fails      = 0;
      reset      = 1'b1;
      go         = 1'b0;
      ld_valid   = 1'b0;
      ld_addr    = 8'd0;
      ld_data    = 8'd0;
      ld_last    = 1'b0;
      res_ready  = 1'b0;
      halt_force = 1'b0;
      halt_after = -1;
      step;
      step;
      reset = 1'b0;
      check_idle_reset();

      // Nominal: halt 40 cycles after start drops.
      pl_addr[0] = 8'd16; pl_data[0] = 8'hFF;
      pl_addr[1] = 8'd17; pl_data[1] = 8'hFF;
      exp_res0.push_back({1'b0, 8'd16, 8'hFF});
      exp_res0.push_back({1'b0, 8'd17, 8'hFF});
      exp_res0.push_back({1'b1, 8'd18, 8'h00});
      exp_res1.push_back({1'b0, 8'd254, 8'h00});
      exp_res1.push_back({1'b0, 8'd255, 8'h00});
      exp_res1.push_back({1'b1, 8'd0, 8'h00});
      do_run(2, 40, 1'b0, 1'b0, 1'b0, 1'b0, 16'd40, 1'b0);

      // Timeout: core never halts.
      pl_addr[0] = 8'd16; pl_data[0] = 8'h11;
      pl_addr[1] = 8'd18; pl_data[1] = 8'h33;
      exp_res0.push_back({1'b0, 8'd16, 8'h11});
      exp_res0.push_back({1'b0, 8'd17, 8'h00});
      exp_res0.push_back({1'b1, 8'd18, 8'h33});
      exp_res1.push_back({1'b0, 8'd254, 8'h00});
      exp_res1.push_back({1'b0, 8'd255, 8'h00});
      exp_res1.push_back({1'b1, 8'd0, 8'h00});
      do_run(2, -1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd100, 1'b1);

      // Reset during RUN cycle 10: no result beats.
      pl_addr[0] = 8'd16; pl_data[0] = 8'h77;
      pl_addr[1] = 8'd17; pl_data[1] = 8'h88;
      do_run(2, 40, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 1'b0);

      // Full nominal run after the abort, with result backpressure.
      pl_addr[0] = 8'd16; pl_data[0] = 8'hFF;
      pl_addr[1] = 8'd17; pl_data[1] = 8'hFF;
      exp_res0.push_back({1'b0, 8'd16, 8'hFF});
      exp_res0.push_back({1'b0, 8'd17, 8'hFF});
      exp_res0.push_back({1'b1, 8'd18, 8'h00});
      exp_res1.push_back({1'b0, 8'd254, 8'h00});
      exp_res1.push_back({1'b0, 8'd255, 8'h00});
      exp_res1.push_back({1'b1, 8'd0, 8'h00});
      do_run(2, 40, 1'b0, 1'b0, 1'b1, 1'b0, 16'd40, 1'b0);

      // Ignored go in LOAD, ignored halt in LAUNCH, address wrap on the 254 instance.
      pl_addr[0] = 8'd254; pl_data[0] = 8'hA1;
      pl_addr[1] = 8'd255; pl_data[1] = 8'hB2;
      pl_addr[2] = 8'd0;   pl_data[2] = 8'hC3;
      exp_res0.push_back({1'b0, 8'd16, 8'h00});
      exp_res0.push_back({1'b0, 8'd17, 8'h00});
      exp_res0.push_back({1'b1, 8'd18, 8'h00});
      exp_res1.push_back({1'b0, 8'd254, 8'hA1});
      exp_res1.push_back({1'b0, 8'd255, 8'hB2});
      exp_res1.push_back({1'b1, 8'd0, 8'hC3});
      do_run(3, 5, 1'b1, 1'b1, 1'b0, 1'b0, 16'd5, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
